cheshire_eoc_hang_monitor: RTL
==============================

Name: cheshire_eoc_hang_monitor

Overview:
- Synthesizable run-status monitor placed directly downstream of the CVA6 commit stage and the SoC scratch register 2 in cheshire.
- Detects end-of-computation from the scratch[0] done bit, then latches the exit code (scratch[31:1]).
- Detects a program-counter hang: the commit PC is unchanged for MaxCycles consecutive cycles.
- Waits DrainCycles after a hang, then raises a final finish indication so that wrapper benches or an FPGA status LED/GPIO can stop or report.

Parameters:
- PcWidth, 64, width of the commit PC.
- MaxCycles, 10000, consecutive unchanged-PC cycles that declare a hang (must be ≥ 2).
- DrainCycles, 100, cycles spent in DRAIN between hang detection and finish (must be ≥ 1).
- CntWidth, $clog2(MaxCycles+DrainCycles+1), derived; do not override.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous restart to IDLE; clears all latched results
- commit_ack_i  in  1  commit port 0 acknowledge
- commit_pc_i  in  PcWidth  commit port 0 PC, sampled every cycle
- scratch_i  in  32  current value of scratch register 2
- running_o  out  1  high in RUN
- eoc_o  out  1  end-of-computation reached (sticky)
- exit_code_o  out  31  latched scratch_i[31:1] at EOC
- fail_o  out  1  eoc_o and exit_code_o != 0
- hang_o  out  1  hang detected (sticky)
- hang_pc_o  out  PcWidth  PC at which the hang was detected
- finish_o  out  1  sticky; set on EOC or at the end of DRAIN

Behaviour:
- Reset (async, rst_ni low): state IDLE, all counters 0, old_pc 0, all outputs 0.
- clear_i has priority over all other events and returns the block to the reset values synchronously.
- States: IDLE, RUN, DRAIN, DONE.
- EOC detection:
  - In IDLE, RUN or DRAIN, when scratch_i[0]==1 at a clock edge, the next state is DONE.
  - The same edge sets eoc_o, latches exit_code_o=scratch_i[31:1] and sets finish_o.
  - All of these outputs are visible the cycle after the sampling edge (1-cycle latency).
- EOC has priority over hang detection and over the IDLE->RUN transition on the same edge.
- EOC during DRAIN:
  - hang_o and hang_pc_o stay set.
  - finish_o is set immediately; the drain is aborted.
- IDLE -> RUN: on the first commit_ack_i==1, load old_pc=commit_pc_i and set cnt=0.
- RUN, every cycle, regardless of commit_ack_i:
  - If commit_pc_i==old_pc, cnt increments and saturates at MaxCycles.
  - Otherwise old_pc<=commit_pc_i and cnt<=0.
- RUN -> DRAIN: when the registered cnt==MaxCycles.
  - hang_o is set and hang_pc_o<=old_pc.
  - Net effect: hang_o rises MaxCycles+1 cycles after the last PC change.
- DRAIN:
  - cnt is reused as the drain counter, reset to 0 on entry and incremented every cycle.
  - When cnt==DrainCycles-1, go to DONE and set finish_o (DrainCycles cycles after hang_o rises).
- DONE: absorbing state. All outputs hold until clear_i or reset. Later scratch_i changes are ignored.
- fail_o is combinational from the registered eoc_o and exit_code_o.
- running_o is combinational from the state.
- Reset asserted mid-DRAIN or mid-RUN: immediate return to reset values; no partial outputs remain.
- No X propagation: old_pc has a defined reset value, and the compare is only meaningful in RUN.

Test Plan:
- Reset, then commit_ack_i pulse with pc=0x8000_0000, then scratch_i=0x0000_0001 -> next cycle eoc_o=1, exit_code_o=0, fail_o=0, finish_o=1, hang_o=0, state DONE.
- RUN with pc incrementing by 4 each cycle, then scratch_i=(5<<1)|1 -> exit_code_o=5, fail_o=1; later scratch_i=0 leaves the outputs unchanged.
- With MaxCycles=16 and DrainCycles=4, pc toggles then holds 0x8000_0100 -> hang_o rises 17 cycles after the last change with hang_pc_o=0x8000_0100; finish_o rises 4 cycles later; eoc_o=0.
- Hang boundary:
  - PC held for 15 cycles then changed (MaxCycles=16) -> no hang; the counter restarts.
  - Holding again for 17 cycles -> hang.
- scratch_i[0] rises on the same edge that cnt reaches MaxCycles -> DONE with eoc_o=1 and hang_o=0.
- EOC in the 2nd DRAIN cycle -> eoc_o=1, hang_o=1 and finish_o=1 on the next cycle.
- Reset and clear:
  - rst_ni asserted mid-DRAIN -> all outputs 0 asynchronously.
  - clear_i in DONE -> IDLE, outputs 0, and the block waits for a new commit_ack_i.

Source files
------------

// File: rtl/cheshire_eoc_hang_monitor.sv
// Run-status monitor: latches end-of-computation exit code and flags commit-PC hangs, then finishes after a drain.
// Latency: all registered outputs appear 1 cycle after the sampling edge; no backpressure, inputs sampled every cycle.
module cheshire_eoc_hang_monitor #(
    parameter int unsigned PcWidth     = 64,
    parameter int unsigned MaxCycles   = 10000,
    parameter int unsigned DrainCycles = 100,
    parameter int unsigned CntWidth    = $clog2(MaxCycles + DrainCycles + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               commit_ack_i,
    input  logic [PcWidth-1:0] commit_pc_i,
    input  logic [31:0]        scratch_i,
    output logic               running_o,
    output logic               eoc_o,
    output logic [30:0]        exit_code_o,
    output logic               fail_o,
    output logic               hang_o,
    output logic [PcWidth-1:0] hang_pc_o,
    output logic               finish_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [CntWidth-1:0] CntMax       = CntWidth'(MaxCycles);
    localparam logic [CntWidth-1:0] CntDrainLast = CntWidth'(DrainCycles - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [PcWidth-1:0]  old_pc_q, old_pc_d;
    logic [PcWidth-1:0]  hang_pc_q, hang_pc_d;
    logic [30:0]         exit_code_q, exit_code_d;
    logic                eoc_q, eoc_d;
    logic                hang_q, hang_d;
    logic                finish_q, finish_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            old_pc_q    <= '0;
            hang_pc_q   <= '0;
            exit_code_q <= '0;
            eoc_q       <= 1'b0;
            hang_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            old_pc_q    <= old_pc_d;
            hang_pc_q   <= hang_pc_d;
            exit_code_q <= exit_code_d;
            eoc_q       <= eoc_d;
            hang_q      <= hang_d;
            finish_q    <= finish_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        old_pc_d    = old_pc_q;
        hang_pc_d   = hang_pc_q;
        exit_code_d = exit_code_q;
        eoc_d       = eoc_q;
        hang_d      = hang_q;
        finish_d    = finish_q;

        if (clear_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            old_pc_d    = '0;
            hang_pc_d   = '0;
            exit_code_d = '0;
            eoc_d       = 1'b0;
            hang_d      = 1'b0;
            finish_d    = 1'b0;
        end else if (state_q != DONE && scratch_i[0]) begin
            // EOC wins over hang detection, drain completion and run start
            state_d     = DONE;
            eoc_d       = 1'b1;
            exit_code_d = scratch_i[31:1];
            finish_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (commit_ack_i) begin
                        state_d  = RUN;
                        old_pc_d = commit_pc_i;
                        cnt_d    = '0;
                    end
                end
                RUN: begin
                    if (cnt_q == CntMax) begin
                        state_d   = DRAIN;
                        hang_d    = 1'b1;
                        hang_pc_d = old_pc_q;
                        cnt_d     = '0;
                    end else if (commit_pc_i == old_pc_q) begin
                        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
                    end else begin
                        old_pc_d = commit_pc_i;
                        cnt_d    = '0;
                    end
                end
                DRAIN: begin
                    if (cnt_q == CntDrainLast) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign running_o   = (state_q == RUN);
    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_code_q;
    assign fail_o      = eoc_q && (exit_code_q != '0);
    assign hang_o      = hang_q;
    assign hang_pc_o   = hang_pc_q;
    assign finish_o    = finish_q;

endmodule
